// File: rtl/sensor_pkg.sv
// Shared types and constants for the two-channel ultrasonic ranging scheduler.
// Timing defaults assume a 100 MHz clock.
package sensor_pkg;

    localparam int DIST_W = 22;
    localparam int TMR_W  = 23;

    localparam int TRIG_CYCLES_DEF  = 1100;
    localparam int ECHO_TIMEOUT_DEF = 3_000_000;
    localparam int GUARD_CYCLES_DEF = 6_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_GUARD     = 3'd4
    } state_t;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sensor_scheduler_if.sv
// Bundle of the ranging control, sensor pins and result outputs.
// master = controller/sensor side, slave = the scheduler.
interface sensor_scheduler_if;
    import sensor_pkg::*;

    logic              en;
    logic [1:0]        echo;
    logic [1:0]        trig;
    logic [DIST_W-1:0] dist0;
    logic [DIST_W-1:0] dist1;
    // valid[n] is a one-cycle strobe with no back-pressure: dist/timeout for channel n
    // are stable from that cycle until the next strobe of the same channel.
    logic [1:0]        valid;
    logic [1:0]        timeout;
    logic              busy;
    state_t            state_dbg;

    modport master (
        output en, echo,
        input  trig, dist0, dist1, valid, timeout, busy, state_dbg
    );

    modport slave (
        input  en, echo,
        output trig, dist0, dist1, valid, timeout, busy, state_dbg
    );

endinterface

// File: rtl/sensor_echo_sync.sv
// Two-flop synchronizer for one asynchronous echo line, plus single-cycle
// rise/fall pulses derived from the synchronized level.
module sensor_echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sensor_scheduler.sv
// Alternates trigger/measure/guard cycles between the left (ch0) and right (ch1)
// sensors using one shared timer; echo widths are reported in clock cycles.
module sensor_scheduler
    import sensor_pkg::*;
#(
    parameter int TRIG_CYCLES  = TRIG_CYCLES_DEF,
    parameter int ECHO_TIMEOUT = ECHO_TIMEOUT_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
    input logic               clk,
    input logic               rst_n,
    sensor_scheduler_if.slave bus
);

    localparam logic [TMR_W-1:0]  TRIG_LAST  = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMO_LAST   = TMR_W'(ECHO_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  GUARD_LAST = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [DIST_W-1:0] DIST_SAT   = DIST_W'(ECHO_TIMEOUT - 1);

    state_t            state_q;
    logic              ch_q;
    logic [TMR_W-1:0]  timer_q;
    logic [1:0]        trig_q;
    logic [1:0]        valid_q;
    logic [1:0]        timeout_q;
    logic [DIST_W-1:0] dist0_q;
    logic [DIST_W-1:0] dist1_q;

    logic [1:0] echo_sync;
    logic [1:0] echo_rise;
    logic [1:0] echo_fall;

    sensor_echo_sync u_sync0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(bus.echo[0]),
        .sync_o (echo_sync[0]),
        .rise_o (echo_rise[0]),
        .fall_o (echo_fall[0])
    );

    sensor_echo_sync u_sync1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(bus.echo[1]),
        .sync_o (echo_sync[1]),
        .rise_o (echo_rise[1]),
        .fall_o (echo_fall[1])
    );

    // Only the selected channel's echo is ever looked at, so cross-talk is inert.
    logic echo_sel;
    logic rise_sel;
    logic fall_sel;

    assign echo_sel = ch_q ? echo_sync[1] : echo_sync[0];
    assign rise_sel = ch_q ? echo_rise[1] : echo_rise[0];
    assign fall_sel = ch_q ? echo_fall[1] : echo_fall[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= 1'b0;
            timer_q   <= '0;
            trig_q    <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
            dist0_q   <= '0;
            dist1_q   <= '0;
        end else begin
            valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    trig_q  <= '0;
                    if (bus.en) begin
                        state_q <= ST_TRIG;
                        trig_q  <= ch_onehot(ch_q);
                    end
                end

                ST_TRIG: begin
                    if (timer_q == TRIG_LAST) begin
                        state_q <= ST_WAIT_RISE;
                        timer_q <= '0;
                        trig_q  <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                // A level already high on entry produces no rise pulse and is ignored.
                ST_WAIT_RISE: begin
                    if (rise_sel) begin
                        state_q <= ST_MEASURE;
                        timer_q <= '0;
                    end else if (timer_q == TMO_LAST) begin
                        state_q            <= ST_GUARD;
                        timer_q            <= '0;
                        timeout_q[ch_q]    <= 1'b1;
                        valid_q            <= ch_onehot(ch_q);
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                ST_MEASURE: begin
                    if (fall_sel) begin
                        state_q         <= ST_GUARD;
                        timer_q         <= '0;
                        timeout_q[ch_q] <= 1'b0;
                        valid_q         <= ch_onehot(ch_q);
                        if (ch_q) dist1_q <= timer_q[DIST_W-1:0];
                        else      dist0_q <= timer_q[DIST_W-1:0];
                    end else if (timer_q == TMO_LAST) begin
                        state_q         <= ST_GUARD;
                        timer_q         <= '0;
                        timeout_q[ch_q] <= 1'b1;
                        valid_q         <= ch_onehot(ch_q);
                        if (ch_q) dist1_q <= DIST_SAT;
                        else      dist0_q <= DIST_SAT;
                    end else if (echo_sel) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                ST_GUARD: begin
                    if (timer_q == GUARD_LAST) begin
                        timer_q <= '0;
                        ch_q    <= ~ch_q;
                        if (bus.en) begin
                            state_q <= ST_TRIG;
                            trig_q  <= ch_onehot(~ch_q);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    trig_q  <= '0;
                end
            endcase
        end
    end

    assign bus.trig      = trig_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.dist0     = dist0_q;
    assign bus.dist1     = dist1_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed-plus-random bench for sensor_scheduler with short timing parameters;
// expected results come from the ping rules applied to the bench's own echo stimulus.
module tb_sensor_scheduler;
    import sensor_pkg::*;

    localparam int TRIG  = 10;
    localparam int TMO   = 1000;
    localparam int GUARD = 50;

    localparam int M_NORMAL = 0;
    localparam int M_NONE   = 1;
    localparam int M_STUCK  = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sensor_scheduler_if bus_if ();

    sensor_scheduler #(
        .TRIG_CYCLES (TRIG),
        .ECHO_TIMEOUT(TMO),
        .GUARD_CYCLES(GUARD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [1:0]        v;
        logic [DIST_W-1:0] d0;
        logic [DIST_W-1:0] d1;
        logic [1:0]        to;
        int                cyc;
    } obs_t;

    obs_t              obs_q[$];
    logic [DIST_W-1:0] exp_q[$];
    int                m_dist[2];
    int                m_tol[2];
    int                m_to[2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int trig_rises = 0;
    int rise_cyc = 0;
    int last_valid_cyc = 0;
    bit guard_chk = 1'b0;
    logic [1:0] prev_trig = 2'b00;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_near(input string tag, input int got, input int exp, input int tol);
        n_cmp++;
        assert (((got >= exp - tol) && (got <= exp + tol)) === 1'b1) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, got, exp, tol);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("trig_onehot", int'(bus_if.trig & (bus_if.trig - 2'd1)), 0);
            check("valid_not_both", int'(bus_if.valid == 2'b11), 0);
            if (bus_if.trig != 2'b00 && prev_trig == 2'b00) begin
                trig_rises++;
                rise_cyc = cyc;
            end
            prev_trig = bus_if.trig;
            if (bus_if.valid != 2'b00)
                obs_q.push_back('{bus_if.valid, bus_if.dist0, bus_if.dist1, bus_if.timeout, cyc});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_trig(input int ch, output int fall_cyc, output bit ok);
        int rises0;
        int hi;
        rises0 = trig_rises;
        ok = 1'b0;
        fall_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (trig_rises != rises0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("trig_seen", int'(ok), 1);
        if (ok) begin
            check("trig_ch", int'(bus_if.trig), (ch == 1) ? 2 : 1);
            check("single_valid", obs_q.size(), 0);
            obs_q.delete();
            if (guard_chk) check("guard_len", rise_cyc - last_valid_cyc, GUARD);
            hi = 0;
            for (int i = 0; i < 200; i++) begin
                if (bus_if.trig == 2'b00) break;
                hi++;
                step();
            end
            fall_cyc = cyc;
            check("trig_len", hi, TRIG);
        end
    endtask

    task automatic ping(input int ch, input int mode, input int delay, input int width,
                        input bit xtalk, input bit drop_en);
        int   fall_cyc;
        bit   ok;
        int   oc;
        int   got;
        int   other;
        int   exp_to;
        int   exp_tol;
        obs_t r;
        oc = 1 - ch;
        wait_trig(ch, fall_cyc, ok);
        if (!ok) return;

        if (mode == M_NORMAL) begin
            exp_q.push_back(DIST_W'(width));
            exp_to  = 0;
            exp_tol = 1;
        end else if (mode == M_STUCK) begin
            exp_q.push_back(DIST_W'(TMO - 1));
            exp_to  = 1;
            exp_tol = 0;
        end else begin
            exp_q.push_back(DIST_W'(m_dist[ch]));
            exp_to  = 1;
            exp_tol = m_tol[ch];
        end

        if (mode == M_NORMAL) begin
            repeat (delay) step();
            bus_if.echo[ch] = 1'b1;
            for (int i = 0; i < width; i++) begin
                if (xtalk && i == width / 4) bus_if.echo[oc] = 1'b1;
                if (xtalk && i == width / 2) bus_if.echo[oc] = 1'b0;
                if (drop_en && i == width / 2) bus_if.en = 1'b0;
                step();
            end
            bus_if.echo[ch] = 1'b0;
        end else if (mode == M_STUCK) begin
            repeat (delay) step();
            bus_if.echo[0] = 1'b1;
            fork
                begin
                    repeat (5000) step();
                    bus_if.echo[0] = 1'b0;
                end
            join_none
        end

        for (int i = 0; i < 2 * TMO + 200; i++) begin
            if (obs_q.size() != 0) break;
            step();
        end
        check("valid_seen", int'(obs_q.size() != 0), 1);
        if (obs_q.size() == 0) return;

        r = obs_q.pop_front();
        got   = (ch == 1) ? int'(r.d1) : int'(r.d0);
        other = (ch == 1) ? int'(r.d0) : int'(r.d1);
        check("valid_ch", int'(r.v), (ch == 1) ? 2 : 1);
        check_near("dist_sel", got, int'(exp_q.pop_front()), exp_tol);
        check("timeout_sel", int'(r.to[ch]), exp_to);
        check_near("dist_other", other, m_dist[oc], m_tol[oc]);
        check("timeout_other", int'(r.to[oc]), m_to[oc]);
        if (mode == M_NONE) check("wait_window", r.cyc - fall_cyc, TMO);

        if (mode == M_NORMAL) begin
            m_dist[ch] = width;
            m_tol[ch]  = 1;
        end else if (mode == M_STUCK) begin
            m_dist[ch] = TMO - 1;
            m_tol[ch]  = 0;
        end
        m_to[ch]       = exp_to;
        last_valid_cyc = r.cyc;
        guard_chk      = !drop_en;
    endtask

    task automatic rnd_ping(input int ch, input bit xtalk, input bit drop_en);
        ping(ch, M_NORMAL, $urandom_range(100, 5), $urandom_range(850, 20), xtalk, drop_en);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rises0;
        bit seen;
        bus_if.en   = 1'b0;
        bus_if.echo = 2'b00;
        for (int c = 0; c < 2; c++) begin
            m_dist[c] = 0;
            m_tol[c]  = 0;
            m_to[c]   = 0;
        end
        repeat (3) step();
        check("rst_trig", int'(bus_if.trig), 0);
        check("rst_valid", int'(bus_if.valid), 0);
        check("rst_timeout", int'(bus_if.timeout), 0);
        check("rst_dist0", int'(bus_if.dist0), 0);
        check("rst_dist1", int'(bus_if.dist1), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_state", int'(bus_if.state_dbg), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_no_en", int'(bus_if.busy), 0);
        bus_if.en = 1'b1;

        // normal ping, no echo, stuck echo and its aftermath
        ping(0, M_NORMAL, 30, 200, 1'b0, 1'b0);
        ping(1, M_NONE, 0, 0, 1'b0, 1'b0);
        ping(0, M_STUCK, 30, 0, 1'b0, 1'b0);
        ping(1, M_NONE, 0, 0, 1'b0, 1'b0);
        ping(0, M_NONE, 0, 0, 1'b0, 1'b0);
        ping(1, M_NONE, 0, 0, 1'b0, 1'b0);
        ping(0, M_NONE, 0, 0, 1'b0, 1'b0);
        rnd_ping(1, 1'b0, 1'b0);
        ping(0, M_NORMAL, 30, 300, 1'b0, 1'b0);

        // random pings, with cross-talk on channel 1 during a channel 0 measurement
        rnd_ping(1, 1'b0, 1'b0);
        rnd_ping(0, 1'b1, 1'b0);
        ping(1, M_NONE, 0, 0, 1'b0, 1'b0);
        rnd_ping(0, 1'b1, 1'b0);
        rnd_ping(1, 1'b0, 1'b0);

        // enable dropped mid-measurement
        rnd_ping(0, 1'b0, 1'b1);
        repeat (GUARD + 5) step();
        check("endrop_state", int'(bus_if.state_dbg), int'(ST_IDLE));
        check("endrop_busy", int'(bus_if.busy), 0);
        check("endrop_trig", int'(bus_if.trig), 0);
        rises0 = trig_rises;
        repeat (200) step();
        check("endrop_no_trig", trig_rises - rises0, 0);
        check("endrop_no_valid", obs_q.size(), 0);
        check_near("endrop_dist0_hold", int'(bus_if.dist0), m_dist[0], m_tol[0]);
        bus_if.en = 1'b1;
        rnd_ping(1, 1'b0, 1'b0);

        // reset during a channel 0 trigger
        rises0 = trig_rises;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (trig_rises != rises0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("rst_trig_seen", int'(seen), 1);
        check("rst_trig_ch", int'(bus_if.trig), 1);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("mid_rst_trig", int'(bus_if.trig), 0);
        check("mid_rst_valid", int'(bus_if.valid), 0);
        check("mid_rst_timeout", int'(bus_if.timeout), 0);
        check("mid_rst_dist0", int'(bus_if.dist0), 0);
        check("mid_rst_dist1", int'(bus_if.dist1), 0);
        check("mid_rst_busy", int'(bus_if.busy), 0);
        check("mid_rst_no_valid", obs_q.size(), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            m_dist[c] = 0;
            m_tol[c]  = 0;
            m_to[c]   = 0;
        end
        guard_chk = 1'b0;
        rnd_ping(0, 1'b0, 1'b0);
        rnd_ping(1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
